// File: rtl/move_store_pkg.sv
// Shared definitions for the move result store: FSM states, record layout and read timing.
package move_store_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR   = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    localparam int FLAGS_WIDTH  = 12;
    localparam int ATTACK_WIDTH = 64;
    localparam int READ_LATENCY = 3;

    // Record layout, LSB first: flags, castle, board, then the optional attack maps.
    localparam int OFF_CAP    = 0;
    localparam int OFF_BIC    = 1;
    localparam int OFF_WIC    = 2;
    localparam int OFF_WTM    = 3;
    localparam int OFF_EP     = 4;
    localparam int OFF_CASTLE = 8;
    localparam int OFF_BOARD  = 12;

    function automatic int record_width_base(int board_w);
        return board_w + FLAGS_WIDTH;
    endfunction

    function automatic int record_width_attack(int board_w);
        return board_w + FLAGS_WIDTH + 2 * ATTACK_WIDTH;
    endfunction

    localparam int MOVE_RECORD_WIDTH        = record_width_base(256);
    localparam int MOVE_RECORD_WIDTH_ATTACK = record_width_attack(256);

endpackage

// File: rtl/move_store_if.sv
// Generator-side write channel and control-side read channel of the move store.
interface move_store_if #(
    parameter int BOARD_WIDTH        = 256,
    parameter int MAX_POSITIONS_LOG2 = 8
);
    logic                          gen_valid;
    logic                          gen_ready;
    logic                          gen_done;
    logic [BOARD_WIDTH-1:0]        gen_board;
    logic [3:0]                    gen_castle_mask;
    logic [3:0]                    gen_en_passant_col;
    logic                          gen_white_to_move;
    logic                          gen_white_in_check;
    logic                          gen_black_in_check;
    logic                          gen_capture;
    logic [63:0]                   gen_white_is_attacking;
    logic [63:0]                   gen_black_is_attacking;

    logic [MAX_POSITIONS_LOG2-1:0] move_index;
    logic                          moves_ready;
    logic [MAX_POSITIONS_LOG2:0]   move_count;
    logic                          move_ready;
    logic                          overflow;
    logic [BOARD_WIDTH-1:0]        move_board;
    logic [3:0]                    move_castle_mask;
    logic [3:0]                    move_en_passant_col;
    logic                          move_white_to_move;
    logic                          move_white_in_check;
    logic                          move_black_in_check;
    logic                          move_capture;
    logic [63:0]                   move_white_is_attacking;
    logic [63:0]                   move_black_is_attacking;

    modport master (
        output gen_valid, gen_done, gen_board, gen_castle_mask, gen_en_passant_col,
               gen_white_to_move, gen_white_in_check, gen_black_in_check, gen_capture,
               gen_white_is_attacking, gen_black_is_attacking, move_index,
        input  gen_ready, moves_ready, move_count, move_ready, overflow, move_board,
               move_castle_mask, move_en_passant_col, move_white_to_move, move_white_in_check,
               move_black_in_check, move_capture, move_white_is_attacking, move_black_is_attacking
    );

    modport slave (
        input  gen_valid, gen_done, gen_board, gen_castle_mask, gen_en_passant_col,
               gen_white_to_move, gen_white_in_check, gen_black_in_check, gen_capture,
               gen_white_is_attacking, gen_black_is_attacking, move_index,
        output gen_ready, moves_ready, move_count, move_ready, overflow, move_board,
               move_castle_mask, move_en_passant_col, move_white_to_move, move_white_in_check,
               move_black_in_check, move_capture, move_white_is_attacking, move_black_is_attacking
    );
endinterface

// File: rtl/move_store_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered read, no array reset.
module move_store_ram #(
    parameter int DATA_W = 268,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/move_store.sv
// Move result store: collects generated positions into RAM, then serves them by index.
// Define MOVE_STORE_ATTACK_EN to also store the white/black attack maps.
module move_store
    import move_store_pkg::*;
#(
    parameter int PIECE_WIDTH        = 4,
    parameter int BOARD_WIDTH        = 64 * PIECE_WIDTH,
    parameter int MAX_POSITIONS_LOG2 = 8
) (
    input  logic         clk,
    input  logic         aresetb,
    input  logic         clear_moves,
    move_store_if.slave  bus
);
`ifdef MOVE_STORE_ATTACK_EN
    localparam int REC_W    = record_width_attack(BOARD_WIDTH);
    localparam int OFF_WATK = OFF_BOARD + BOARD_WIDTH;
    localparam int OFF_BATK = OFF_WATK + ATTACK_WIDTH;
`else
    localparam int REC_W    = record_width_base(BOARD_WIDTH);
`endif
    localparam int CNT_W = MAX_POSITIONS_LOG2 + 1;

    state_e                        state_q, state_d;
    logic [CNT_W-1:0]              count_q;
    logic                          ovf_q, full, wr_en, done_q, start;
    logic [MAX_POSITIONS_LOG2-1:0] idx_q, rd_addr_p0;
    logic                          vld_p0, vld_p1, hit_p0, hit_p1, rdy_q;
    logic [REC_W-1:0]              wr_data, rd_data_p1, rec_p2;

    always_ff @(posedge clk or negedge aresetb) begin
        if (!aresetb) state_q <= ST_CLEAR;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear_moves) begin
            state_d = ST_CLEAR;
        end else begin
            case (state_q)
                ST_CLEAR:   state_d = ST_COLLECT;
                ST_COLLECT: if (bus.gen_done) state_d = ST_DONE;
                ST_DONE:    state_d = ST_DONE;
                default:    state_d = ST_CLEAR;
            endcase
        end
    end

    assign full          = count_q[CNT_W-1];
    assign bus.gen_ready = (state_q == ST_COLLECT) && !full;
    assign wr_en         = bus.gen_valid && bus.gen_ready && !clear_moves;

    always_ff @(posedge clk or negedge aresetb) begin
        if (!aresetb) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (clear_moves || state_q == ST_CLEAR) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (wr_en) count_q <= count_q + CNT_W'(1);
            if (state_q == ST_COLLECT && bus.gen_valid && full) ovf_q <= 1'b1;
        end
    end

    always_comb begin
        wr_data                           = '0;
        wr_data[OFF_CAP]                  = bus.gen_capture;
        wr_data[OFF_BIC]                  = bus.gen_black_in_check;
        wr_data[OFF_WIC]                  = bus.gen_white_in_check;
        wr_data[OFF_WTM]                  = bus.gen_white_to_move;
        wr_data[OFF_EP +: 4]              = bus.gen_en_passant_col;
        wr_data[OFF_CASTLE +: 4]          = bus.gen_castle_mask;
        wr_data[OFF_BOARD +: BOARD_WIDTH] = bus.gen_board;
`ifdef MOVE_STORE_ATTACK_EN
        wr_data[OFF_WATK +: ATTACK_WIDTH] = bus.gen_white_is_attacking;
        wr_data[OFF_BATK +: ATTACK_WIDTH] = bus.gen_black_is_attacking;
`endif
    end

    move_store_ram #(.DATA_W(REC_W), .ADDR_W(MAX_POSITIONS_LOG2)) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (count_q[MAX_POSITIONS_LOG2-1:0]),
        .wr_data (wr_data),
        .rd_addr (rd_addr_p0),
        .rd_data (rd_data_p1)
    );

    // A fresh read launches on DONE entry or any index change and cancels any read in flight.
    assign start = (state_q == ST_DONE) && !clear_moves && (!done_q || bus.move_index != idx_q);

    always_ff @(posedge clk or negedge aresetb) begin
        if (!aresetb) begin
            done_q <= 1'b0;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            rdy_q  <= 1'b0;
        end else if (clear_moves || state_q != ST_DONE) begin
            done_q <= 1'b0;
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            rdy_q  <= 1'b0;
        end else begin
            done_q <= 1'b1;
            vld_p0 <= start;
            vld_p1 <= vld_p0 && !start;
            if (start)       rdy_q <= 1'b0;
            else if (vld_p1) rdy_q <= 1'b1;
        end
    end

    // p0: latch index as RAM address; p1: RAM data out; p2: output register
    always_ff @(posedge clk) begin
        idx_q      <= bus.move_index;
        rd_addr_p0 <= bus.move_index;
        hit_p0     <= {1'b0, bus.move_index} < count_q;
        hit_p1     <= hit_p0;
    end

    always_ff @(posedge clk or negedge aresetb) begin
        if (!aresetb)
            rec_p2 <= '0;
        else if (clear_moves)
            rec_p2 <= '0;
        else if (state_q == ST_DONE && vld_p1 && !start)
            rec_p2 <= hit_p1 ? rd_data_p1 : '0;
    end

    assign bus.moves_ready         = (state_q == ST_DONE);
    assign bus.move_count          = count_q;
    assign bus.overflow            = ovf_q;
    assign bus.move_ready          = rdy_q;
    assign bus.move_board          = rec_p2[OFF_BOARD +: BOARD_WIDTH];
    assign bus.move_castle_mask    = rec_p2[OFF_CASTLE +: 4];
    assign bus.move_en_passant_col = rec_p2[OFF_EP +: 4];
    assign bus.move_white_to_move  = rec_p2[OFF_WTM];
    assign bus.move_white_in_check = rec_p2[OFF_WIC];
    assign bus.move_black_in_check = rec_p2[OFF_BIC];
    assign bus.move_capture        = rec_p2[OFF_CAP];
`ifdef MOVE_STORE_ATTACK_EN
    assign bus.move_white_is_attacking = rec_p2[OFF_WATK +: ATTACK_WIDTH];
    assign bus.move_black_is_attacking = rec_p2[OFF_BATK +: ATTACK_WIDTH];
`else
    logic unused_attack;
    assign unused_attack = ^{bus.gen_white_is_attacking, bus.gen_black_is_attacking};
    assign bus.move_white_is_attacking = '0;
    assign bus.move_black_is_attacking = '0;
`endif
endmodule

// File: tb/tb_move_store.sv
// Self-checking bench for move_store: collect, indexed reads, overflow, clear and async reset.
module tb_move_store;
    import move_store_pkg::*;

    localparam int BW   = 256;
    localparam int LOG2 = 8;
    localparam int CAP  = 256;

    typedef struct packed {
        logic [63:0]   batk;
        logic [63:0]   watk;
        logic [BW-1:0] board;
        logic [3:0]    castle;
        logic [3:0]    ep;
        logic          wtm;
        logic          wic;
        logic          bic;
        logic          cap;
    } tb_rec_t;

    typedef struct {
        int idx;
        bit zero;
    } vec_t;

    logic clk = 1'b0;
    logic aresetb;
    logic clear_moves;

    move_store_if #(.BOARD_WIDTH(BW), .MAX_POSITIONS_LOG2(LOG2)) bus();

    move_store #(.PIECE_WIDTH(4), .BOARD_WIDTH(BW), .MAX_POSITIONS_LOG2(LOG2)) dut (
        .clk         (clk),
        .aresetb     (aresetb),
        .clear_moves (clear_moves),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int      n_vec = 0;
    int      n_err = 0;
    int      cnt   = 0;
    tb_rec_t model [CAP];
    tb_rec_t sb [$];
    vec_t    tbl [7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [511:0] act, logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic tb_rec_t make_rec(int s);
        tb_rec_t     r;
        logic [31:0] h;
        h = (s + 1) * 32'h9E3779B1;
        for (int k = 0; k < 8; k++) r.board[k*32 +: 32] = h ^ (k * 32'h85EBCA6B) ^ s;
        r.castle = h[3:0];
        r.ep     = h[11:8];
        r.wtm    = h[16];
        r.wic    = h[17];
        r.bic    = h[18];
        r.cap    = h[19];
        r.watk   = {h, ~h};
        r.batk   = {~h ^ 32'h5A5A5A5A, h + 32'd1};
        return r;
    endfunction

    // What the read port should show for a stored record in this build.
    function automatic tb_rec_t view(tb_rec_t r);
        tb_rec_t v;
        v = r;
`ifndef MOVE_STORE_ATTACK_EN
        v.watk = '0;
        v.batk = '0;
`endif
        return v;
    endfunction

    function automatic tb_rec_t cur_rec();
        tb_rec_t r;
        r.board  = bus.move_board;
        r.castle = bus.move_castle_mask;
        r.ep     = bus.move_en_passant_col;
        r.wtm    = bus.move_white_to_move;
        r.wic    = bus.move_white_in_check;
        r.bic    = bus.move_black_in_check;
        r.cap    = bus.move_capture;
        r.watk   = bus.move_white_is_attacking;
        r.batk   = bus.move_black_is_attacking;
        return r;
    endfunction

    task automatic drive_rec(tb_rec_t r);
        bus.gen_board              = r.board;
        bus.gen_castle_mask        = r.castle;
        bus.gen_en_passant_col     = r.ep;
        bus.gen_white_to_move      = r.wtm;
        bus.gen_white_in_check     = r.wic;
        bus.gen_black_in_check     = r.bic;
        bus.gen_capture            = r.cap;
        bus.gen_white_is_attacking = r.watk;
        bus.gen_black_is_attacking = r.batk;
    endtask

    task automatic put(tb_rec_t r, bit done);
        drive_rec(r);
        bus.gen_valid = 1'b1;
        bus.gen_done  = done;
        if (cnt < CAP) begin
            model[cnt] = r;
            cnt++;
        end
        step();
        bus.gen_valid = 1'b0;
        bus.gen_done  = 1'b0;
    endtask

    // Called in the cycle a read is issued; pops the scoreboard when move_ready rises.
    task automatic wait_read(string name);
        int      lat;
        tb_rec_t exp;
        step();
        lat = 1;
        chk({name, " ready drop"}, 512'(bus.move_ready), 512'(0));
        while (!bus.move_ready && lat < 10) begin
            step();
            lat++;
        end
        chk({name, " latency"}, 512'(lat), 512'(READ_LATENCY));
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty, got %0h expected an entry", name, cur_rec());
        end else begin
            exp = sb.pop_front();
            chk({name, " record"}, cur_rec(), exp);
        end
    endtask

    task automatic issue_read(int idx, bit zero, string name);
        bus.move_index = LOG2'(idx);
        sb.push_back(zero ? tb_rec_t'(0) : view(model[idx]));
        wait_read(name);
    endtask

    task automatic check_idle(string tag);
        chk({tag, " count"},       512'(bus.move_count),  512'(0));
        chk({tag, " moves_ready"}, 512'(bus.moves_ready), 512'(0));
        chk({tag, " move_ready"},  512'(bus.move_ready),  512'(0));
        chk({tag, " overflow"},    512'(bus.overflow),    512'(0));
        chk({tag, " gen_ready"},   512'(bus.gen_ready),   512'(0));
        chk({tag, " record"},      cur_rec(),             512'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{idx: 1,   zero: 1'b0};
        tbl[1] = '{idx: 2,   zero: 1'b0};
        tbl[2] = '{idx: 5,   zero: 1'b1};
        tbl[3] = '{idx: 0,   zero: 1'b0};
        tbl[4] = '{idx: 3,   zero: 1'b1};
        tbl[5] = '{idx: 255, zero: 1'b1};
        tbl[6] = '{idx: 2,   zero: 1'b0};

        aresetb        = 1'b0;
        clear_moves    = 1'b0;
        bus.gen_valid  = 1'b0;
        bus.gen_done   = 1'b0;
        bus.move_index = '0;
        drive_rec(tb_rec_t'(0));
        #12;
        check_idle("reset");
        aresetb = 1'b1;
        step();
        chk("collect gen_ready", 512'(bus.gen_ready), 512'(1));

        // Three records, done with the third; index 0 served on DONE entry.
        put(make_rec(1), 1'b0);
        put(make_rec(2), 1'b0);
        chk("pre-done moves_ready", 512'(bus.moves_ready), 512'(0));
        put(make_rec(3), 1'b1);
        chk("A count", 512'(bus.move_count), 512'(3));
        chk("A moves_ready", 512'(bus.moves_ready), 512'(1));
        chk("A gen_ready", 512'(bus.gen_ready), 512'(0));
        sb.push_back(view(model[0]));
        wait_read("A idx0");

        // Index stepped 2 -> 1 -> 0 on consecutive cycles: only index 0 completes.
        bus.move_index = 8'd2;
        step();
        chk("B ready low 1", 512'(bus.move_ready), 512'(0));
        bus.move_index = 8'd1;
        step();
        chk("B ready low 2", 512'(bus.move_ready), 512'(0));
        issue_read(0, 1'b0, "B idx0");

        bus.gen_valid = 1'b1;
        step();
        bus.gen_valid = 1'b0;
        chk("done valid overflow", 512'(bus.overflow), 512'(0));
        chk("done valid count", 512'(bus.move_count), 512'(3));

        for (int i = 0; i < 7; i++) issue_read(tbl[i].idx, tbl[i].zero, $sformatf("tbl%0d", i));

        // Clear during an outstanding read, with a simultaneous offered record and done.
        bus.move_index = 8'd1;
        step();
        clear_moves = 1'b1;
        drive_rec(make_rec(40));
        bus.gen_valid = 1'b1;
        bus.gen_done  = 1'b1;
        step();
        check_idle("clear read");
        bus.gen_valid = 1'b0;
        bus.gen_done  = 1'b0;
        clear_moves   = 1'b0;
        cnt = 0;
        step();
        chk("release gen_ready", 512'(bus.gen_ready), 512'(1));
        chk("release count", 512'(bus.move_count), 512'(0));

        // Clear during collection beats a same-cycle record and done.
        put(make_rec(50), 1'b0);
        put(make_rec(51), 1'b0);
        chk("C count", 512'(bus.move_count), 512'(2));
        clear_moves = 1'b1;
        drive_rec(make_rec(52));
        bus.gen_valid = 1'b1;
        bus.gen_done  = 1'b1;
        step();
        check_idle("clear collect");
        bus.gen_valid = 1'b0;
        bus.gen_done  = 1'b0;
        clear_moves   = 1'b0;
        cnt = 0;
        step();
        chk("release2 gen_ready", 512'(bus.gen_ready), 512'(1));
        bus.move_index = 8'd0;
        put(make_rec(60), 1'b1);
        chk("C2 count", 512'(bus.move_count), 512'(1));
        sb.push_back(view(model[0]));
        wait_read("C2 addr0");

        // Fill to capacity, overflow, then read the last entry.
        clear_moves = 1'b1;
        step();
        clear_moves = 1'b0;
        cnt = 0;
        step();
        bus.move_index = 8'd255;
        for (int i = 0; i < CAP; i++) put(make_rec(1000 + i), 1'b0);
        chk("full count", 512'(bus.move_count), 512'(256));
        chk("full gen_ready", 512'(bus.gen_ready), 512'(0));
        chk("full overflow pre", 512'(bus.overflow), 512'(0));
        put(make_rec(5000), 1'b0);
        chk("overflow set", 512'(bus.overflow), 512'(1));
        chk("overflow count", 512'(bus.move_count), 512'(256));
        bus.gen_done = 1'b1;
        step();
        bus.gen_done = 1'b0;
        chk("full moves_ready", 512'(bus.moves_ready), 512'(1));
        chk("full overflow sticky", 512'(bus.overflow), 512'(1));
        sb.push_back(view(model[255]));
        wait_read("full idx255");

        // Asynchronous reset mid-cycle in DONE.
        #3;
        aresetb = 1'b0;
        #1;
        check_idle("async");
        aresetb = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/move_store.md
# move_store

Result buffer between the move generator and the control/AXI register block. Captures each generated successor position (board plus side-to-move, castle, en-passant, check, capture and attack flags) into an on-chip RAM, reports completion and total count, then serves any stored move by index to the control block with a fixed read latency. It drives `initial_moves_ready`, `initial_move_count`, `initial_move_ready` and the `initial_*` record fields the control block exposes over AXI.

## Interface
- `PIECE_WIDTH`, default 4: bits per square.
- `BOARD_WIDTH`, default 256: `64*PIECE_WIDTH`.
- `MAX_POSITIONS_LOG2`, default 8: entry address width; capacity is `2**MAX_POSITIONS_LOG2`.

Ports:
- `clk`, in, 1: sole clock.
- `aresetb`, in, 1: asynchronous active-low reset.
- `clear_moves`, in, 1: level. While high, holds the store empty.
- `gen_valid`, in, 1: generator record valid.
- `gen_ready`, out, 1: store can accept a record.
- `gen_done`, in, 1: single-cycle pulse marking end of generation.
- `gen_board`, in, `BOARD_WIDTH`: successor board.
- `gen_castle_mask`, in, 4: castle mask field.
- `gen_en_passant_col`, in, 4: en-passant column field.
- `gen_white_to_move`, `gen_white_in_check`, `gen_black_in_check`, `gen_capture`, in, 1 each: flag fields.
- `gen_white_is_attacking`, `gen_black_is_attacking`, in, 64 each: attack maps.
- `move_index`, in, `MAX_POSITIONS_LOG2`: read index.
- `moves_ready`, out, 1: generation complete.
- `move_count`, out, `MAX_POSITIONS_LOG2+1`: number of stored entries.
- `move_ready`, out, 1: record outputs correspond to the current `move_index`.
- `overflow`, out, 1: sticky. A record was offered while the store was full.
- `move_board`, `move_castle_mask`, `move_en_passant_col`, `move_white_to_move`, `move_white_in_check`, `move_black_in_check`, `move_capture`, `move_white_is_attacking`, `move_black_is_attacking`, out: the stored record, same widths as the `gen_*` inputs.

## Operation
- States: CLEAR, COLLECT, DONE.
- Reset and `clear_moves` high both force CLEAR. CLEAR moves to COLLECT on the first cycle with `clear_moves` low.
- CLEAR behaviour: `move_count`=0, `moves_ready`=0, `move_ready`=0, `overflow`=0, `gen_ready`=0.
- COLLECT:
  - `gen_ready`=1 while `move_count` < capacity.
  - On `gen_valid && gen_ready`, the record is written at address `move_count` and `move_count` increments.
  - `gen_valid` while full: record dropped, `overflow` set.
- `gen_done` in COLLECT moves to DONE and sets `moves_ready`=1.
  - If a record handshake occurs in the same cycle as `gen_done`, that record is stored and counted first.
  - `gen_done` while full still moves to DONE.
  - `gen_done` outside COLLECT is ignored.
- DONE: `gen_ready`=0 and `gen_valid` is ignored (no overflow). Reads are served until `clear_moves`.
- Reads:
  - A registered copy of `move_index` is compared with the input every cycle. A read is issued on entry to DONE or on any index change.
  - `move_ready` drops the cycle after the change is seen.
  - A change during an outstanding read restarts it; only the latest index ever completes.
- `move_index >= move_count`: record outputs all-zero and `move_ready` still asserts with normal latency.
- Record outputs hold their last value until the next read completes. They are zero after reset or clear.
- `clear_moves` mid-read aborts the read.

## Timing
- Every output resets to 0.
- Write: record is stored in cycle T. `move_count` updates at T+1.
- `moves_ready` rises the cycle after `gen_done` is sampled.
- Read latency: index change sampled at cycle T, RAM address at T+1, RAM data at T+2, output register and `move_ready`=1 at T+3.
- First read after DONE entry: `move_ready` at DONE+3.
- Simultaneous `clear_moves` and `gen_valid`/`gen_done`: clear wins and nothing is stored.

## Configuration
- `MOVE_STORE_ATTACK_EN` defined:
  - Attack maps are stored.
  - RAM word is `BOARD_WIDTH+140` bits.
- Undefined:
  - Attack maps are not stored.
  - RAM word is `BOARD_WIDTH+12` bits.
  - `move_*_is_attacking` tied to 0.
  - The `gen_*_is_attacking` inputs remain on the port list and are ignored.

## Structure
- Shared package holds:
  - the state enum;
  - `MOVE_RECORD_WIDTH` with and without attack;
  - field offsets for packing and unpacking the record;
  - `READ_LATENCY`=3.
- Sub-module `move_store_ram`: simple dual-port RAM, one write port and one read port, registered read, parameterised width and depth, no reset on the array.
- The top level holds the FSM, counter, index compare, pack/unpack and output registers.

## Test plan
- Reset, then 3 records with `gen_done` on the third -> `move_count`=3; `moves_ready` rises 1 cycle later; index 0 yields record 0 with `move_ready` at DONE+3.
- In DONE, index stepped 2→1→0 on consecutive cycles -> `move_ready` low throughout and rises only for index 0, 3 cycles after the last change.
- `move_index`=5 with count 3 -> all-zero record with `move_ready`=1.
- Fill all 256 entries, then offer one more -> `gen_ready`=0, `overflow`=1, count stays 256; `gen_done` -> DONE; index 255 returns the last stored record.
- `clear_moves` asserted mid-read and mid-collect -> all outputs 0 the next cycle; `gen_ready` returns 1 cycle after release; new collection starts at address 0.
- `aresetb` pulsed low asynchronously in DONE -> outputs 0 immediately; with the macro undefined, attack outputs stay 0 throughout.
